// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and load/store; DONE/RVALID follow MEM_EN by MEM_LAT cycles.
// Backpressure: requesters hold REQ until their GNT pulse; no new request is sampled while an access is in flight.
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RST_F,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_RVALID,
    output logic [DW-1:0] IF_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_DONE,
    output logic [DW-1:0] D_RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY
);

    localparam int LW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          win_d_q, win_d_d;
    logic          st_q, st_d;
    logic          if_gnt_q, if_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;
    logic          data_wins;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        win_d_d      = win_d_q;
        st_d         = st_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_done_d     = 1'b0;
        d_rdata_d    = d_rdata_q;
        data_wins    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!IF_REQ) begin
                    starve_cnt_d = '0;
                end
                if (IF_REQ || D_REQ) begin
                    // Data normally wins; a fetch that has lost STARVE_MAX times in a row is forced through.
                    data_wins   = D_REQ && !(IF_REQ && (starve_cnt_q == SW'(STARVE_MAX)));
                    win_d_d     = data_wins;
                    st_d        = data_wins && D_WE;
                    if_gnt_d    = !data_wins;
                    d_gnt_d     = data_wins;
                    mem_en_d    = 1'b1;
                    mem_we_d    = data_wins && D_WE;
                    mem_addr_d  = data_wins ? D_ADDR : IF_ADDR;
                    if (data_wins) begin
                        mem_wdata_d = D_WDATA;
                    end
                    lat_cnt_d   = LW'(MEM_LAT);
                    state_d     = WAIT;
                    if (!data_wins) begin
                        starve_cnt_d = '0;
                    end else if (IF_REQ && (starve_cnt_q != SW'(STARVE_MAX))) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == LW'(1)) begin
                    state_d = IDLE;
                    if (win_d_q) begin
                        d_done_d = 1'b1;
                        if (!st_q) begin
                            d_rdata_d = MEM_RDATA;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = MEM_RDATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            win_d_q      <= 1'b0;
            st_q         <= 1'b0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_done_q     <= 1'b0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            win_d_q      <= win_d_d;
            st_q         <= st_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_done_q     <= d_done_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign IF_GNT    = if_gnt_q;
    assign IF_RVALID = if_rvalid_q;
    assign IF_RDATA  = if_rdata_q;
    assign D_GNT     = d_gnt_q;
    assign D_DONE    = d_done_q;
    assign D_RDATA   = d_rdata_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) with a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_f = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    logic          if_gnt[2], if_rvalid[2], d_gnt[2], d_done[2], mem_en[2], mem_we[2], busy[2];
    logic [DW-1:0] if_rdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
    logic [AW-1:0] mem_addr[2];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut_lat2 (
        .CLK(clk), .RST_F(rst_f),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt[0]), .IF_RVALID(if_rvalid[0]), .IF_RDATA(if_rdata[0]),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(d_gnt[0]), .D_DONE(d_done[0]), .D_RDATA(d_rdata[0]),
        .MEM_EN(mem_en[0]), .MEM_WE(mem_we[0]), .MEM_ADDR(mem_addr[0]), .MEM_WDATA(mem_wdata[0]),
        .MEM_RDATA(mem_rdata[0]), .BUSY(busy[0])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_lat1 (
        .CLK(clk), .RST_F(rst_f),
        .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt[1]), .IF_RVALID(if_rvalid[1]), .IF_RDATA(if_rdata[1]),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(d_gnt[1]), .D_DONE(d_done[1]), .D_RDATA(d_rdata[1]),
        .MEM_EN(mem_en[1]), .MEM_WE(mem_we[1]), .MEM_ADDR(mem_addr[1]), .MEM_WDATA(mem_wdata[1]),
        .MEM_RDATA(mem_rdata[1]), .BUSY(busy[1])
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction

    // Memory devices seen by each DUT; contents forgotten on reset.
    logic          dev_wr[2][256];
    logic [DW-1:0] dev_val[2][256];
    always @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 256; a++) dev_wr[k][a] <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (mem_en[k] && mem_we[k]) begin
                    dev_wr[k][mem_addr[k]]  <= 1'b1;
                    dev_val[k][mem_addr[k]] <= mem_wdata[k];
                end
        end
    end
    always_comb begin
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = (dev_wr[k][mem_addr[k]] === 1'b1) ? dev_val[k][mem_addr[k]] : init_word(mem_addr[k]);
    end

    logic          sel = 1'b0;
    logic          o_if_gnt, o_if_rvalid, o_d_gnt, o_d_done, o_mem_en, o_mem_we, o_busy;
    logic [DW-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;
    always_comb begin
        o_if_gnt    = if_gnt[sel];
        o_if_rvalid = if_rvalid[sel];
        o_if_rdata  = if_rdata[sel];
        o_d_gnt     = d_gnt[sel];
        o_d_done    = d_done[sel];
        o_d_rdata   = d_rdata[sel];
        o_mem_en    = mem_en[sel];
        o_mem_we    = mem_we[sel];
        o_mem_addr  = mem_addr[sel];
        o_mem_wdata = mem_wdata[sel];
        o_busy      = busy[sel];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference model: one access at a time; completion lat edges after grant, next sample one edge later.
    int            cyc = 0;
    int            lat = 2;
    int            gnt_edge = 0;
    int            starve = 0;
    bit            pend = 0, p_is_d = 0, p_we = 0;
    logic [AW-1:0] p_addr = '0;
    bit            ref_wr[2][256];
    logic [DW-1:0] ref_val[2][256];
    logic          e_if_gnt, e_d_gnt, e_en, e_we, e_rv, e_done, e_busy;
    logic [AW-1:0] e_maddr = '0;
    logic [DW-1:0] e_mwdata = '0, e_if_rdata = '0, e_d_rdata = '0;
    bit            hold_if = 0, hold_d = 0;
    byte           gq[$];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[sel][a] ? ref_val[sel][a] : init_word(a);
    endfunction

    task automatic model_reset();
        {e_if_gnt, e_d_gnt, e_en, e_we, e_rv, e_done, e_busy} = '0;
        pend = 0; starve = 0;
        e_maddr = '0; e_mwdata = '0; e_if_rdata = '0; e_d_rdata = '0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) ref_wr[k][a] = 0;
    endtask

    task automatic model_update();
        {e_if_gnt, e_d_gnt, e_en, e_we, e_rv, e_done} = '0;
        if (pend) begin
            if (cyc == gnt_edge + lat) begin
                pend = 0;
                if (p_is_d) begin
                    e_done = 1'b1;
                    if (!p_we) e_d_rdata = ref_read(p_addr);
                end else begin
                    e_rv       = 1'b1;
                    e_if_rdata = ref_read(p_addr);
                end
            end
        end else begin
            if (!if_req) starve = 0;
            if (if_req || d_req) begin
                p_is_d   = d_req && !(if_req && starve == SMAX);
                p_we     = p_is_d && d_we;
                p_addr   = p_is_d ? d_addr : if_addr;
                pend     = 1;
                gnt_edge = cyc;
                e_if_gnt = !p_is_d;
                e_d_gnt  = p_is_d;
                e_en     = 1'b1;
                e_we     = p_we;
                e_maddr  = p_addr;
                if (p_is_d) e_mwdata = d_wdata;
                if (p_we) begin
                    ref_wr[sel][d_addr]  = 1;
                    ref_val[sel][d_addr] = d_wdata;
                end
                if (!p_is_d) starve = 0;
                else if (if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
            end
        end
        e_busy = pend;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst_f) model_reset();
        else model_update();
        #1;
        chk("IF_GNT", 32'(o_if_gnt), 32'(e_if_gnt));
        chk("D_GNT", 32'(o_d_gnt), 32'(e_d_gnt));
        chk("MEM_EN", 32'(o_mem_en), 32'(e_en));
        chk("MEM_WE", 32'(o_mem_we), 32'(e_we));
        chk("BUSY", 32'(o_busy), 32'(e_busy));
        chk("IF_RVALID", 32'(o_if_rvalid), 32'(e_rv));
        chk("D_DONE", 32'(o_d_done), 32'(e_done));
        chk("IF_RDATA", o_if_rdata, e_if_rdata);
        chk("D_RDATA", o_d_rdata, e_d_rdata);
        if (e_en) begin
            chk("MEM_ADDR", 32'(o_mem_addr), 32'(e_maddr));
            if (e_we) chk("MEM_WDATA", o_mem_wdata, e_mwdata);
        end
        if (o_if_gnt) gq.push_back(8'h49);
        if (o_d_gnt)  gq.push_back(8'h44);
        if (o_if_gnt && !hold_if) if_req = 1'b0;
        if (o_d_gnt && !hold_d)   d_req  = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_f = 1'b0;
        step();
        step();
        rst_f = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = AW'($urandom_range(0, 15));
            end else if (if_req && $urandom_range(0, 19) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end else if (d_req && $urandom_range(0, 19) == 0) begin
                d_req = 1'b0;
            end
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        string pat;
        int    rv_cyc[$];
        logic [DW-1:0] rv_dat[$];
        int    ngnt;

        // Reset state
        reset_pulse();

        // Single fetch
        if_req = 1'b1; if_addr = 8'h10;
        for (int i = 0; i < 4; i++) step();

        // Store, then a load of the same word
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        for (int i = 0; i < 4; i++) step();
        chk("LOAD_AFTER_STORE", o_d_rdata, 32'hDEADBEEF);

        // Both requesters held high: starvation guard pattern
        reset_pulse();
        gq.delete();
        hold_if = 1; hold_d = 1;
        if_req = 1'b1; if_addr = 8'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h41;
        for (int i = 0; i < 24; i++) step();
        hold_if = 0; hold_d = 0;
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        pat = "DDDIDDDI";
        chk("ORDER_COUNT", 32'(gq.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk("ORDER", 32'(gq[i]), 32'(pat[i]));

        // Data request raised during a fetch's wait
        if_req = 1'b1; if_addr = 8'h05;
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h06;
        for (int i = 0; i < 7; i++) step();

        // Reset in the middle of a fetch
        if_req = 1'b1; if_addr = 8'h30;
        step();
        step();
        rst_f = 1'b0;
        #1;
        chk("RST_BUSY", 32'(o_busy), 32'd0);
        chk("RST_MEM_EN", 32'(o_mem_en), 32'd0);
        chk("RST_MEM_ADDR", 32'(o_mem_addr), 32'd0);
        chk("RST_MEM_WDATA", o_mem_wdata, 32'd0);
        chk("RST_IF_RDATA", o_if_rdata, 32'd0);
        chk("RST_D_RDATA", o_d_rdata, 32'd0);
        chk("RST_IF_RVALID", 32'(o_if_rvalid), 32'd0);
        if_req = 1'b0;
        step();
        step();
        rst_f = 1'b1;
        if_req = 1'b1; if_addr = 8'h31;
        for (int i = 0; i < 4; i++) step();
        chk("POST_RST_FETCH", o_if_rdata, init_word(8'h31));

        random_phase(300);

        // MEM_LAT=1 instance: back-to-back fetches
        sel = 1'b1; lat = 1;
        reset_pulse();
        hold_if = 1; ngnt = 0;
        if_req = 1'b1; if_addr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_if_rvalid) begin
                rv_cyc.push_back(cyc);
                rv_dat.push_back(o_if_rdata);
            end
            if (o_if_gnt) begin
                ngnt++;
                if_addr = if_addr + 1'b1;
                if (ngnt == 3) if_req = 1'b0;
            end
        end
        hold_if = 0;
        chk("LAT1_RV_COUNT", 32'(rv_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < rv_dat.size(); i++) chk("LAT1_RV_DATA", rv_dat[i], init_word(AW'(i)));
        for (int i = 1; i < 3 && i < rv_cyc.size(); i++) chk("LAT1_RV_SPACING", 32'(rv_cyc[i] - rv_cyc[i-1]), 32'd2);

        random_phase(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
